// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one memory data port between core and host, with anti-starvation, host lock and tagged read return
module dm_port_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        c_req_i,
  input  logic        c_wen_i,
  input  logic [31:0] c_addr_i,
  input  logic [31:0] c_din_i,
  output logic        c_gnt_o,
  output logic        c_rvalid_o,
  output logic [31:0] c_dout_o,
  input  logic        h_req_i,
  input  logic        h_wen_i,
  input  logic [31:0] h_addr_i,
  input  logic [31:0] h_din_i,
  input  logic        h_lock_i,
  output logic        h_gnt_o,
  output logic        h_rvalid_o,
  output logic [31:0] h_dout_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_din_o,
  input  logic [31:0] mem_dout_i
);
  localparam int WW = HOST_MAX_WAIT > 0 ? $clog2(HOST_MAX_WAIT + 1) : 1;
  localparam int TW = 2 * RD_LATENCY;
  localparam logic [WW-1:0] MAX_W = WW'(HOST_MAX_WAIT);
  localparam logic [0:0] ARB = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;
  logic [0:0] state;
  logic [WW-1:0] wait_cnt;
  logic [TW-1:0] tag;
  logic [31:0] c_dout_q, h_dout_q;
  logic rd_v;
  assign h_gnt_o = h_req_i & ((state == LOCK) | ~c_req_i | (wait_cnt == MAX_W));
  assign c_gnt_o = c_req_i & (state == ARB) & ~h_gnt_o;
  assign mem_wen_o = (c_gnt_o & c_wen_i) | (h_gnt_o & h_wen_i);
  assign mem_addr_o = h_gnt_o ? h_addr_i : c_gnt_o ? c_addr_i : '0;
  assign mem_din_o = h_gnt_o ? h_din_i : c_gnt_o ? c_din_i : '0;
  assign rd_v = (c_gnt_o & ~c_wen_i) | (h_gnt_o & ~h_wen_i);
  // tag pipe entry = {valid, is_host}; the oldest entry sits in the top two bits
  assign c_rvalid_o = tag[TW-1] & ~tag[TW-2];
  assign h_rvalid_o = tag[TW-1] & tag[TW-2];
  assign c_dout_o = c_rvalid_o ? mem_dout_i : c_dout_q;
  assign h_dout_o = h_rvalid_o ? mem_dout_i : h_dout_q;
  // in LOCK every host request is granted, so both states share one next-state rule
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ARB;
      wait_cnt <= '0;
      tag <= '0;
      c_dout_q <= '0;
      h_dout_q <= '0;
    end else begin
      state <= (h_gnt_o & h_lock_i) ? LOCK : ARB;
      wait_cnt <= (h_req_i & ~h_gnt_o) ? ((wait_cnt == MAX_W) ? wait_cnt : wait_cnt + 1'b1) : '0;
      tag <= TW'({tag, rd_v, h_gnt_o});
      c_dout_q <= c_dout_o;
      h_dout_q <= h_dout_o;
    end
  end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed bench with read-return scoreboards for two parameterisations
module tb_dm_port_arbiter;
  logic clk, rst_n;
  int tests, fails;
  logic a_c_req, a_c_wen, a_c_gnt, a_c_rvalid, a_h_req, a_h_wen, a_h_lock, a_h_gnt, a_h_rvalid, a_mem_wen;
  logic [31:0] a_c_addr, a_c_din, a_c_dout, a_h_addr, a_h_din, a_h_dout, a_mem_addr, a_mem_din, a_mem_dout;
  logic b_c_req, b_c_wen, b_c_gnt, b_c_rvalid, b_h_req, b_h_wen, b_h_lock, b_h_gnt, b_h_rvalid, b_mem_wen;
  logic [31:0] b_c_addr, b_c_din, b_c_dout, b_h_addr, b_h_din, b_h_dout, b_mem_addr, b_mem_din, b_mem_dout;
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] a_rd [2];
  logic [31:0] b_rd;
  logic [32:0] q_a [$];
  logic [32:0] q_b [$];
  logic [32:0] ea, eb;
  dm_port_arbiter #(.RD_LATENCY(2), .HOST_MAX_WAIT(8)) u_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .c_req_i(a_c_req), .c_wen_i(a_c_wen), .c_addr_i(a_c_addr), .c_din_i(a_c_din),
    .c_gnt_o(a_c_gnt), .c_rvalid_o(a_c_rvalid), .c_dout_o(a_c_dout),
    .h_req_i(a_h_req), .h_wen_i(a_h_wen), .h_addr_i(a_h_addr), .h_din_i(a_h_din), .h_lock_i(a_h_lock),
    .h_gnt_o(a_h_gnt), .h_rvalid_o(a_h_rvalid), .h_dout_o(a_h_dout),
    .mem_wen_o(a_mem_wen), .mem_addr_o(a_mem_addr), .mem_din_o(a_mem_din), .mem_dout_i(a_mem_dout)
  );
  dm_port_arbiter #(.RD_LATENCY(1), .HOST_MAX_WAIT(0)) u_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .c_req_i(b_c_req), .c_wen_i(b_c_wen), .c_addr_i(b_c_addr), .c_din_i(b_c_din),
    .c_gnt_o(b_c_gnt), .c_rvalid_o(b_c_rvalid), .c_dout_o(b_c_dout),
    .h_req_i(b_h_req), .h_wen_i(b_h_wen), .h_addr_i(b_h_addr), .h_din_i(b_h_din), .h_lock_i(b_h_lock),
    .h_gnt_o(b_h_gnt), .h_rvalid_o(b_h_rvalid), .h_dout_o(b_h_dout),
    .mem_wen_o(b_mem_wen), .mem_addr_o(b_mem_addr), .mem_din_o(b_mem_din), .mem_dout_i(b_mem_dout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (a_mem_wen) mem_a[a_mem_addr[9:2]] <= a_mem_din;
    a_rd[0] <= mem_a[a_mem_addr[9:2]];
    a_rd[1] <= a_rd[0];
    if (b_mem_wen) mem_b[b_mem_addr[9:2]] <= b_mem_din;
    b_rd <= mem_b[b_mem_addr[9:2]];
  end
  assign a_mem_dout = a_rd[1];
  assign b_mem_dout = b_rd;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  // scoreboards: every read return must match the oldest expected {is_host, data}
  always begin
    @(negedge clk);
    #1;
    if (a_c_rvalid | a_h_rvalid) begin
      if (q_a.size() == 0) chk("a_unexpected_rvalid", {30'd0, a_h_rvalid, a_c_rvalid}, 32'd0);
      else begin
        ea = q_a.pop_front();
        chk("a_sb_owner", {30'd0, a_h_rvalid, a_c_rvalid}, ea[32] ? 32'd2 : 32'd1);
        chk("a_sb_data", ea[32] ? a_h_dout : a_c_dout, ea[31:0]);
      end
    end
    if (b_c_rvalid | b_h_rvalid) begin
      if (q_b.size() == 0) chk("b_unexpected_rvalid", {30'd0, b_h_rvalid, b_c_rvalid}, 32'd0);
      else begin
        eb = q_b.pop_front();
        chk("b_sb_owner", {30'd0, b_h_rvalid, b_c_rvalid}, eb[32] ? 32'd2 : 32'd1);
        chk("b_sb_data", eb[32] ? b_h_dout : b_c_dout, eb[31:0]);
      end
    end
  end
  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    {a_c_req, a_c_wen, a_h_req, a_h_wen, a_h_lock} = '0;
    {a_c_addr, a_c_din, a_h_addr, a_h_din} = '0;
    {b_c_req, b_c_wen, b_h_req, b_h_wen, b_h_lock} = '0;
    {b_c_addr, b_c_din, b_h_addr, b_h_din} = '0;
    cyc();
    cyc();
    #2;
    chk("rst_gnt", {30'd0, a_h_gnt, a_c_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, a_h_rvalid, a_c_rvalid}, 32'd0);
    chk("rst_c_dout", a_c_dout, 32'd0);
    chk("rst_h_dout", a_h_dout, 32'd0);
    chk("rst_mem", {31'd0, a_mem_wen} | a_mem_addr | a_mem_din, 32'd0);
    rst_n = 1'b1;
    // core-only write then read, latency 1
    cyc();
    b_c_req = 1; b_c_wen = 1; b_c_addr = 32'h8000_2000; b_c_din = 32'hDEAD_BEEF;
    #2;
    chk("b_wr_gnt", {31'd0, b_c_gnt}, 32'd1);
    chk("b_wr_mem_wen", {31'd0, b_mem_wen}, 32'd1);
    chk("b_wr_mem_addr", b_mem_addr, 32'h8000_2000);
    chk("b_wr_mem_din", b_mem_din, 32'hDEAD_BEEF);
    cyc();
    b_c_wen = 0;
    #2;
    chk("b_rd_gnt", {31'd0, b_c_gnt}, 32'd1);
    chk("b_rd_mem_wen", {31'd0, b_mem_wen}, 32'd0);
    q_b.push_back({1'b0, 32'hDEAD_BEEF});
    cyc();
    b_c_req = 0;
    #2;
    chk("b_rd_rvalid", {30'd0, b_h_rvalid, b_c_rvalid}, 32'd1);
    chk("b_rd_dout", b_c_dout, 32'hDEAD_BEEF);
    chk("b_idle_mem_addr", b_mem_addr, 32'd0);
    cyc();
    #2;
    chk("b_rvalid_pulse", {30'd0, b_h_rvalid, b_c_rvalid}, 32'd0);
    chk("b_dout_hold", b_c_dout, 32'hDEAD_BEEF);
    // strict host priority with HOST_MAX_WAIT=0
    for (int k = 0; k < 4; k++) begin
      cyc();
      b_c_req = 1; b_c_wen = 1; b_c_addr = 32'h8000_0100;
      b_h_req = 1; b_h_wen = 1; b_h_addr = 32'h8000_0104; b_h_din = 32'(k);
      #2;
      chk("b_strict_gnt", {30'd0, b_h_gnt, b_c_gnt}, 32'd2);
      chk("b_strict_addr", b_mem_addr, 32'h8000_0104);
    end
    cyc();
    b_c_req = 0; b_h_req = 0;
    // contention: 8 core grants, then 1 host grant, repeated
    for (int k = 0; k < 18; k++) begin
      cyc();
      a_c_req = 1; a_c_wen = 1; a_c_addr = 32'h8000_0100; a_c_din = 32'h1111_0000 + 32'(k);
      a_h_req = 1; a_h_wen = 1; a_h_addr = 32'h8000_0104; a_h_din = 32'h2222_0000 + 32'(k);
      #2;
      chk("a_contend_gnt", {30'd0, a_h_gnt, a_c_gnt}, (k % 9 == 8) ? 32'd2 : 32'd1);
    end
    cyc();
    a_c_req = 0; a_h_req = 0;
    // lock burst of 4 host writes while the core keeps requesting
    for (int k = 0; k < 5; k++) begin
      cyc();
      a_c_req = (k != 0);
      a_c_addr = 32'h8000_0100;
      a_h_req = (k < 4); a_h_wen = 1; a_h_lock = (k < 3);
      a_h_addr = 32'h8000_0000 + 32'(4 * k); a_h_din = 32'hA0A0_0000 + 32'(k);
      #2;
      chk("a_lock_gnt", {30'd0, a_h_gnt, a_c_gnt}, (k < 4) ? 32'd2 : 32'd1);
      chk("a_lock_addr", a_mem_addr, (k < 4) ? 32'h8000_0000 + 32'(4 * k) : 32'h8000_0100);
    end
    // interleaved reads, latency 2
    cyc();
    a_c_req = 1; a_c_wen = 0; a_c_addr = 32'h8000_0000;
    a_h_req = 0; a_h_lock = 0;
    #2;
    chk("a_il_c_gnt", {30'd0, a_h_gnt, a_c_gnt}, 32'd1);
    q_a.push_back({1'b0, 32'hA0A0_0000});
    cyc();
    a_c_req = 0;
    a_h_req = 1; a_h_wen = 0; a_h_addr = 32'h8000_0008;
    #2;
    chk("a_il_h_gnt", {30'd0, a_h_gnt, a_c_gnt}, 32'd2);
    q_a.push_back({1'b1, 32'hA0A0_0002});
    cyc();
    a_h_req = 0;
    #2;
    chk("a_il_c_rvalid", {30'd0, a_h_rvalid, a_c_rvalid}, 32'd1);
    chk("a_il_c_dout", a_c_dout, 32'hA0A0_0000);
    cyc();
    #2;
    chk("a_il_h_rvalid", {30'd0, a_h_rvalid, a_c_rvalid}, 32'd2);
    chk("a_il_h_dout", a_h_dout, 32'hA0A0_0002);
    cyc();
    #2;
    chk("a_il_quiet", {30'd0, a_h_rvalid, a_c_rvalid}, 32'd0);
    // reset while a host read is in flight
    cyc();
    a_h_req = 1; a_h_wen = 0; a_h_addr = 32'h8000_0000;
    #2;
    chk("a_rr_h_gnt", {31'd0, a_h_gnt}, 32'd1);
    cyc();
    a_h_req = 0;
    rst_n = 1'b0;
    #2;
    chk("a_rr_in_reset", {30'd0, a_h_rvalid, a_c_rvalid}, 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #2;
      chk("a_rr_rvalid", {30'd0, a_h_rvalid, a_c_rvalid}, 32'd0);
      chk("a_rr_douts", a_c_dout | a_h_dout, 32'd0);
      chk("a_rr_gnt", {30'd0, a_h_gnt, a_c_gnt}, 32'd0);
    end
    chk("a_sb_empty", 32'(q_a.size()), 32'd0);
    chk("b_sb_empty", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
